// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard and stall controller for a five-stage in-order pipeline. It detects
// load-use hazards between ID and EX. It freezes the front end while a
// multi-cycle divide runs, and guards that divide with a watchdog. It also
// discards wrong-path instructions after taken jumps and accepted traps.
//
// Ports
//   clk                 core clock
//   rst                 synchronous active-high reset
//   id_reg1_rd_en_i     ID stage reads rs1
//   id_reg1_rd_adder_i  rs1 address
//   id_reg2_rd_en_i     ID stage reads rs2
//   id_reg2_rd_adder_i  rs2 address
//   ex_mem_rd_en_i      EX instruction is a load
//   ex_reg_wr_adder_i   EX destination register
//   ex_div_start_i      EX launches a divide
//   div_ready_i         divider result-valid pulse
//   ex_jump_en_i        taken branch/jump resolved in EX
//   int_assert_i        trap/interrupt accepted
//   hold_pc_o, hold_if_id_o, hold_id_ex_o   freeze the PC / pipeline register
//   flush_if_id_o, flush_id_ex_o            turn the pipeline register into a bubble
//   div_kill_o          abort the divider
//   div_err_o           divider watchdog fired
//   state_o             controller state (0 idle, 1 divide wait, 2 flush)
//   stall_cnt_o         saturating count of cycles with the PC held

module pipe_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DIV_MAX_CYCLES = 34
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_reg1_rd_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg1_rd_adder_i,
  input  logic                      id_reg2_rd_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_reg2_rd_adder_i,
  input  logic                      ex_mem_rd_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_wr_adder_i,
  input  logic                      ex_div_start_i,
  input  logic                      div_ready_i,
  input  logic                      ex_jump_en_i,
  input  logic                      int_assert_i,
  output logic                      hold_pc_o,
  output logic                      hold_if_id_o,
  output logic                      hold_id_ex_o,
  output logic                      flush_if_id_o,
  output logic                      flush_id_ex_o,
  output logic                      div_kill_o,
  output logic                      div_err_o,
  output logic [1:0]                state_o,
  output logic [15:0]               stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_WAIT = 2'd1,
    FLUSH    = 2'd2,
    UNUSED   = 2'd3
  } state_t;

  // The watchdog has to hold values up to DIV_MAX_CYCLES-1.
  localparam int WD_WIDTH = $clog2(DIV_MAX_CYCLES + 1);
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(DIV_MAX_CYCLES - 1);

  state_t              state, state_next;
  logic [WD_WIDTH-1:0] wd_cnt, wd_next;
  logic                load_use;

  // A load into x0 never creates a hazard, because x0 is hard-wired to zero.
  assign load_use = ex_mem_rd_en_i && (ex_reg_wr_adder_i != '0) &&
                    ((id_reg1_rd_en_i && (id_reg1_rd_adder_i == ex_reg_wr_adder_i)) ||
                     (id_reg2_rd_en_i && (id_reg2_rd_adder_i == ex_reg_wr_adder_i)));

  // The state register reads as IDLE for the whole time reset is held, not
  // only after the first clock edge.
  assign state_o = rst ? IDLE : state;

  // Registered state: the FSM state, the divide watchdog and the stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wd_cnt      <= '0;
      stall_cnt_o <= '0;
    end else begin
      state  <= state_next;
      wd_cnt <= wd_next;
      if (hold_pc_o && (stall_cnt_o != 16'hFFFF))
        stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end

  // Next-state and output decode. Within each state, only the event with the
  // highest priority takes effect. The unreachable encoding behaves like IDLE.
  // Every output is forced low while reset is held.
  always_comb begin
    state_next    = state;
    wd_next       = wd_cnt;
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    div_kill_o    = 1'b0;
    div_err_o     = 1'b0;

    case (state)
      DIV_WAIT: begin
        if (int_assert_i) begin
          div_kill_o    = 1'b1;
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          state_next    = FLUSH;
        end else if (div_ready_i) begin
          state_next = IDLE;
        end else if (wd_cnt == WD_LAST) begin
          div_kill_o = 1'b1;
          div_err_o  = 1'b1;
          state_next = IDLE;
        end else begin
          hold_pc_o    = 1'b1;
          hold_if_id_o = 1'b1;
          hold_id_ex_o = 1'b1;
          wd_next      = wd_cnt + WD_WIDTH'(1);
        end
      end

      FLUSH: begin
        // This discards the second wrong-path fetch. A new trap restarts the
        // flush sequence instead of returning to IDLE.
        flush_if_id_o = 1'b1;
        if (int_assert_i) begin
          flush_id_ex_o = 1'b1;
          state_next    = FLUSH;
        end else begin
          state_next = IDLE;
        end
      end

      default: begin
        if (int_assert_i || ex_jump_en_i) begin
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          state_next    = FLUSH;
        end else if (ex_div_start_i) begin
          hold_pc_o    = 1'b1;
          hold_if_id_o = 1'b1;
          hold_id_ex_o = 1'b1;
          wd_next      = '0;
          state_next   = DIV_WAIT;
        end else if (load_use) begin
          // A one-bubble stall: freeze the front end and let the load advance.
          hold_pc_o     = 1'b1;
          hold_if_id_o  = 1'b1;
          flush_id_ex_o = 1'b1;
          state_next    = IDLE;
        end
      end
    endcase

    if (rst) begin
      hold_pc_o     = 1'b0;
      hold_if_id_o  = 1'b0;
      hold_id_ex_o  = 1'b0;
      flush_if_id_o = 1'b0;
      flush_id_ex_o = 1'b0;
      div_kill_o    = 1'b0;
      div_err_o     = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
// Directed testbench for pipe_hazard_ctrl. Inputs change on the falling clock
// edge. Outputs are sampled 1 ns later, so each sample lands mid-cycle.
// Control outputs are packed as
// {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, div_kill, div_err}.

module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_reg1_rd_en, id_reg2_rd_en, ex_mem_rd_en;
  logic [4:0]  id_reg1_rd_adder, id_reg2_rd_adder, ex_reg_wr_adder;
  logic        ex_div_start, div_ready, ex_jump_en, int_assert;
  logic        hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex;
  logic        div_kill, div_err;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [6:0]  ctl;

  int testsRun    = 0;
  int testsFailed = 0;

  localparam logic [6:0] CTL_NONE     = 7'b0000000;
  localparam logic [6:0] CTL_LOADUSE  = 7'b1100100;
  localparam logic [6:0] CTL_HOLD_ALL = 7'b1110000;
  localparam logic [6:0] CTL_FLUSH2   = 7'b0001100;
  localparam logic [6:0] CTL_FLUSH_IF = 7'b0001000;
  localparam logic [6:0] CTL_WDOG     = 7'b0000011;
  localparam logic [6:0] CTL_INT_DIV  = 7'b0001110;

  assign ctl = {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, div_kill, div_err};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .DIV_MAX_CYCLES(34)) dut (
    .clk(clk), .rst(rst),
    .id_reg1_rd_en_i(id_reg1_rd_en), .id_reg1_rd_adder_i(id_reg1_rd_adder),
    .id_reg2_rd_en_i(id_reg2_rd_en), .id_reg2_rd_adder_i(id_reg2_rd_adder),
    .ex_mem_rd_en_i(ex_mem_rd_en), .ex_reg_wr_adder_i(ex_reg_wr_adder),
    .ex_div_start_i(ex_div_start), .div_ready_i(div_ready),
    .ex_jump_en_i(ex_jump_en), .int_assert_i(int_assert),
    .hold_pc_o(hold_pc), .hold_if_id_o(hold_if_id), .hold_id_ex_o(hold_id_ex),
    .flush_if_id_o(flush_if_id), .flush_id_ex_o(flush_id_ex),
    .div_kill_o(div_kill), .div_err_o(div_err),
    .state_o(state), .stall_cnt_o(stall_cnt)
  );

  // One comparison: count it and report a mismatch.
  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then settle before sampling.
  task automatic applyStimulus(input logic r,
                               input logic r1en, input logic [4:0] r1,
                               input logic r2en, input logic [4:0] r2,
                               input logic ld, input logic [4:0] wa,
                               input logic dst, input logic rdy,
                               input logic jmp, input logic intr);
    @(negedge clk);
    rst = r;
    id_reg1_rd_en = r1en; id_reg1_rd_adder = r1;
    id_reg2_rd_en = r2en; id_reg2_rd_adder = r2;
    ex_mem_rd_en = ld; ex_reg_wr_adder = wa;
    ex_div_start = dst; div_ready = rdy; ex_jump_en = jmp; int_assert = intr;
    #1;
  endtask

  task automatic quiet();
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
  endtask

  task automatic resetCycle();
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset with a trap and a jump pending: every output stays low.
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1);
    applyStimulus(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 1);
    checkOutput("reset_ctl", 16'(ctl), 16'(CTL_NONE));
    checkOutput("reset_state", 16'(state), 16'd0);
    checkOutput("reset_stall", stall_cnt, 16'd0);

    // A load to x5 in EX while ID reads rs2 = x5: a single bubble.
    applyStimulus(0, 1, 5'd3, 1, 5'd5, 1, 5'd5, 0, 0, 0, 0);
    checkOutput("loaduse_ctl", 16'(ctl), 16'(CTL_LOADUSE));
    checkOutput("loaduse_state", 16'(state), 16'd0);
    quiet();
    checkOutput("loaduse_release", 16'(ctl), 16'(CTL_NONE));
    checkOutput("loaduse_stall", stall_cnt, 16'd1);

    // A load to x0 creates no hazard.
    applyStimulus(0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 0, 0);
    checkOutput("x0_ctl", 16'(ctl), 16'(CTL_NONE));
    // rs1 matches, but the ID stage does not read rs1.
    applyStimulus(0, 0, 5'd7, 0, 5'd2, 1, 5'd7, 0, 0, 0, 0);
    checkOutput("noread_ctl", 16'(ctl), 16'(CTL_NONE));
    // rs1 hazard.
    applyStimulus(0, 1, 5'd9, 0, 5'd0, 1, 5'd9, 0, 0, 0, 0);
    checkOutput("rs1_ctl", 16'(ctl), 16'(CTL_LOADUSE));
    quiet();
    checkOutput("stall_after_rs1", stall_cnt, 16'd2);

    // Divide start beats load-use.
    resetCycle();
    applyStimulus(0, 1, 5'd4, 0, 5'd0, 1, 5'd4, 1, 0, 0, 0);
    checkOutput("div_start_ctl", 16'(ctl), 16'(CTL_HOLD_ALL));
    checkOutput("div_start_state", 16'(state), 16'd0);
    // Ten DIV_WAIT cycles without ready. A jump partway through is ignored.
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, (i == 5), 0);
      checkOutput($sformatf("div_wait_ctl_%0d", i), 16'(ctl), 16'(CTL_HOLD_ALL));
      checkOutput($sformatf("div_wait_state_%0d", i), 16'(state), 16'd1);
    end
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0);
    checkOutput("div_ready_ctl", 16'(ctl), 16'(CTL_NONE));
    checkOutput("div_ready_state", 16'(state), 16'd1);
    quiet();
    checkOutput("div_done_state", 16'(state), 16'd0);
    checkOutput("div_done_stall", stall_cnt, 16'd11);

    // Reset in the middle of DIV_WAIT clears the watchdog.
    resetCycle();
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0);
    for (int i = 1; i <= 20; i++) quiet();
    checkOutput("mid_div_state", 16'(state), 16'd1);
    resetCycle();
    checkOutput("mid_div_rst_ctl", 16'(ctl), 16'(CTL_NONE));
    checkOutput("mid_div_rst_state", 16'(state), 16'd0);

    // Watchdog: with no ready pulse, the error fires on the 34th DIV_WAIT cycle.
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0);
    checkOutput("wd_start_stall", stall_cnt, 16'd0);
    for (int i = 1; i <= 33; i++) begin
      quiet();
      checkOutput($sformatf("wd_hold_%0d", i), 16'(ctl), 16'(CTL_HOLD_ALL));
    end
    quiet();
    checkOutput("wd_fire_ctl", 16'(ctl), 16'(CTL_WDOG));
    checkOutput("wd_fire_state", 16'(state), 16'd1);
    quiet();
    checkOutput("wd_after_ctl", 16'(ctl), 16'(CTL_NONE));
    checkOutput("wd_after_state", 16'(state), 16'd0);
    checkOutput("wd_after_stall", stall_cnt, 16'd34);

    // A jump and a load-use in the same cycle: the jump wins, with no hold.
    resetCycle();
    applyStimulus(0, 1, 5'd6, 0, 5'd0, 1, 5'd6, 0, 0, 1, 0);
    checkOutput("jump_ctl", 16'(ctl), 16'(CTL_FLUSH2));
    checkOutput("jump_state", 16'(state), 16'd0);
    quiet();
    checkOutput("flush_ctl", 16'(ctl), 16'(CTL_FLUSH_IF));
    checkOutput("flush_state", 16'(state), 16'd2);
    quiet();
    checkOutput("post_flush_ctl", 16'(ctl), 16'(CTL_NONE));
    checkOutput("post_flush_state", 16'(state), 16'd0);
    checkOutput("jump_stall", stall_cnt, 16'd0);

    // An interrupt beats a divide start in IDLE.
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 1);
    checkOutput("int_vs_div_ctl", 16'(ctl), 16'(CTL_FLUSH2));
    quiet();
    checkOutput("int_vs_div_state", 16'(state), 16'd2);

    // An interrupt in DIV_WAIT, together with ready, kills the divide.
    resetCycle();
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 0, 0);
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 1);
    checkOutput("int_div_ctl", 16'(ctl), 16'(CTL_INT_DIV));
    checkOutput("int_div_state", 16'(state), 16'd1);
    // A further interrupt in FLUSH re-flushes and stays in FLUSH.
    applyStimulus(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1);
    checkOutput("int_flush_ctl", 16'(ctl), 16'(CTL_FLUSH2));
    checkOutput("int_flush_state", 16'(state), 16'd2);
    quiet();
    checkOutput("still_flush_state", 16'(state), 16'd2);
    checkOutput("still_flush_stall", stall_cnt, 16'd1);
    // Reset during FLUSH.
    resetCycle();
    checkOutput("flush_rst_ctl", 16'(ctl), 16'(CTL_NONE));
    checkOutput("flush_rst_state", 16'(state), 16'd0);
    quiet();
    checkOutput("flush_rst_after_state", 16'(state), 16'd0);
    checkOutput("flush_rst_after_stall", stall_cnt, 16'd0);
    checkOutput("flush_rst_after_ctl", 16'(ctl), 16'(CTL_NONE));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
